mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the microcontroller's MAR/MDR memory interface.
- Accepts read/write requests with an address and 16-bit write data from the MDR memory-side output.
- Performs the access on an internal word array after a programmable number of wait states.
- Returns read data on a tri-stated data output, with a one-cycle ready pulse that the MDR samples on its memory-read enable.

Parameters:
- ADDR_W, 8: address width; array depth = 2**ADDR_W words.
- DATA_W, 16: word width.
- WAIT_STATES, 2: extra clock edges between request acceptance and the access edge; legal range 0..15.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- mem_addr_in  input  ADDR_W  word address from MAR.
- mem_data_in  input  DATA_W  write data from MDR memory-side output.
- read_req  input  1  level request, read.
- write_req  input  1  level request, write.
- par_inject  input  1  parity-error injection for test; ignored without the feature.
- mem_data_out  output  DATA_W  read data to MDR memory-side input; 'hZ when not valid.
- mem_ready  output  1  one-cycle completion pulse, for both read and write.
- mem_busy  output  1  high whenever the FSM is not in IDLE.
- parity_err  output  1  read parity mismatch flag; qualified by mem_ready.

Behaviour:
- Reset, sampled at the posedge:
  - state=IDLE, wait count=0, mem_ready=0, mem_busy=0, parity_err=0, mem_data_out='hZ.
  - Array contents are not cleared.
- State machine: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Request is sampled at an edge where read_req|write_req is high; call that edge E0.
  - Latch address, write data, operation and par_inject.
  - If both requests are high, read wins and the write is dropped.
  - Next state: WAIT with count=WAIT_STATES when WAIT_STATES>0, else ACCESS.
- WAIT: count decrements each edge; when count==1 at an edge, go to ACCESS.
- ACCESS, at its edge:
  - Write: array[addr] <= latched data.
  - Read: output register <= array[addr].
  - Next state: DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency: mem_ready is high for exactly the cycle after edge E(WAIT_STATES+1).
  - WAIT_STATES=0: ready is high in the cycle after E1.
  - WAIT_STATES=2: ready is high in the cycle after E3.
- Read data output:
  - mem_data_out carries the read word only in DONE-of-read.
  - It is 'hZ in every other cycle, including DONE-of-write.
- Write visibility: a read of the same address issued after a write's DONE returns the new data.
- Inputs during a transaction:
  - Requests and inputs are ignored while mem_busy=1.
  - Address and data are taken only at E0; later changes have no effect.
- Requests are level-sensitive. The requester must drop its request in the mem_ready cycle. A request still high when the FSM is back in IDLE is accepted as a new transaction; no back-to-back merge.
- Reset mid-transaction:
  - Before the ACCESS edge: no array write occurs, and no ready pulse.
  - At or after the ACCESS edge: the write is committed, and the FSM still returns to IDLE with outputs at reset values.
- Address wrap: none; every ADDR_W value is a valid index.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each array word stores an extra even-parity bit computed on write, inverted when the latched par_inject=1.
  - On read, parity_err=1 in the DONE cycle if the stored bit mismatches the recomputed parity; 0 otherwise and in all other cycles.
- Undefined:
  - No parity storage; par_inject is unused and parity_err is tied to 0.

Test Plan:
- Reset, then idle 5 cycles: mem_ready=0, mem_busy=0, mem_data_out='hZ throughout.
- WAIT_STATES=2: write 16'hBEEF to addr 8'h12, then read addr 8'h12.
  - Write: ready in the cycle after E3, data_out 'hZ.
  - Read: ready in the cycle after E3, data_out=16'hBEEF only in that cycle.
- Change mem_addr_in to 8'h34 and toggle write_req while busy: no second transaction; array[8'h34] unchanged; exactly one ready pulse.
- read_req=write_req=1 with addr 8'h05 holding 16'h1234, data_in 16'hFFFF: read of 16'h1234 returned; a subsequent read still returns 16'h1234.
- Write 16'hAAAA to addr 8'h40 with reset asserted during WAIT: no ready pulse; a later read of addr 8'h40 returns the old value.
- MEM_PARITY_EN:
  - Write 16'h0001 with par_inject=1, then read it: parity_err=1 with ready.
  - Write again with par_inject=0, then read: parity_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: one request at a time, programmable wait states,
// tri-stated read data with a one-cycle ready pulse. Optional stored parity under `MEM_PARITY_EN.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              read_req,
    input  logic              write_req,
    input  logic              par_inject,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              parity_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_read_q, is_read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                drive_rd;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_ready = 1'b0;
        mem_busy  = 1'b1;
        drive_rd  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_busy = 1'b0;
                if (read_req || write_req) begin
                    addr_d    = mem_addr_in;
                    wdata_d   = mem_data_in;
                    // A simultaneous read and write resolves to the read.
                    is_read_d = read_req;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                mem_ready = 1'b1;
                drive_rd  = is_read_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        is_read_q <= is_read_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
    end

    // The array update ignores reset so an access already at its edge is still committed.
    always_ff @(posedge clock) begin
        if (state_q == ST_ACCESS) begin
            if (is_read_q) begin
                rdata_q <= mem_q[addr_q];
            end else begin
                mem_q[addr_q] <= wdata_q;
            end
        end
    end

    assign mem_data_out = drive_rd ? rdata_q : {DATA_W{1'bz}};

`ifdef MEM_PARITY_EN
    logic inj_q, inj_d;
    logic perr_q;
    logic par_q [DEPTH];

    always_comb begin
        inj_d = inj_q;
        if (state_q == ST_IDLE && (read_req || write_req)) begin
            inj_d = par_inject;
        end
    end

    always_ff @(posedge clock) begin
        inj_q <= inj_d;
        if (state_q == ST_ACCESS && !is_read_q) begin
            par_q[addr_q] <= (^wdata_q) ^ inj_q;
        end
    end

    // Flag is only ever set by the access edge of a read, so it is high exactly in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (state_q == ST_ACCESS && is_read_q) begin
            perr_q <= (par_q[addr_q] != (^mem_q[addr_q]));
        end else begin
            perr_q <= 1'b0;
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_STATES=2): latency, tri-state read data, busy-time
// input immunity, read priority, reset abort and, when MEM_PARITY_EN is defined, parity injection.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  mem_addr_in;
    logic [15:0] mem_data_in;
    logic        read_req;
    logic        write_req;
    logic        par_inject;
    wire  [15:0] dout;
    logic        mem_ready;
    logic        mem_busy;
    logic        parity_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Undriven read data floats to all ones, so 16'hFFFF stands for the high-impedance state.
    pullup (dout);

    localparam logic [15:0] HIZ = 16'hFFFF;

    mem_responder #(
        .ADDR_W(8),
        .DATA_W(16),
        .WAIT_STATES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_addr_in(mem_addr_in),
        .mem_data_in(mem_data_in),
        .read_req(read_req),
        .write_req(write_req),
        .par_inject(par_inject),
        .mem_data_out(dout),
        .mem_ready(mem_ready),
        .mem_busy(mem_busy),
        .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // j counts negedges after the accepting edge E0; with two wait states DONE is j==3.
    // meddle scrambles address/data and toggles write_req while the responder is busy.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [15:0] d, input logic inj,
                           input logic [15:0] exp_data, input logic exp_perr,
                           input logic meddle);
        @(negedge clock);
        read_req    = rd;
        write_req   = wr;
        mem_addr_in = a;
        mem_data_in = d;
        par_inject  = inj;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clock);
            check({tag, "_ready"}, mem_ready, (j == 3));
            check({tag, "_busy"}, mem_busy, (j <= 3));
            check({tag, "_dout"}, dout, (j == 3 && rd) ? exp_data : HIZ);
            check({tag, "_perr"}, parity_err, (j == 3) ? exp_perr : 1'b0);
            if (meddle && j < 3) begin
                mem_addr_in = 8'h34;
                mem_data_in = 16'hDEAD;
                write_req   = (j == 1);
                par_inject  = ~inj;
            end
            if (j == 3) begin
                read_req  = 1'b0;
                write_req = 1'b0;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        mem_addr_in = 8'h00;
        mem_data_in = 16'h0000;
        read_req    = 1'b0;
        write_req   = 1'b0;
        par_inject  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_ready", mem_ready, 1'b0);
            check("idle_busy", mem_busy, 1'b0);
            check("idle_dout", dout, HIZ);
            check("idle_perr", parity_err, 1'b0);
        end

        run_txn("wr_beef", 1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_txn("rd_beef", 1'b1, 1'b0, 8'h12, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0);

        run_txn("wr_34",   1'b0, 1'b1, 8'h34, 16'h0C0C, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_txn("wr_busy", 1'b0, 1'b1, 8'h22, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_txn("rd_34",   1'b1, 1'b0, 8'h34, 16'h0000, 1'b0, 16'h0C0C, 1'b0, 1'b0);
        run_txn("rd_22",   1'b1, 1'b0, 8'h22, 16'h0000, 1'b0, 16'h2222, 1'b0, 1'b0);

        run_txn("wr_05",   1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_txn("rw_05",   1'b1, 1'b1, 8'h05, 16'hFFFF, 1'b0, 16'h1234, 1'b0, 1'b0);
        run_txn("rd_05",   1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0);

        run_txn("wr_40",   1'b0, 1'b1, 8'h40, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clock);
        write_req   = 1'b1;
        mem_addr_in = 8'h40;
        mem_data_in = 16'hAAAA;
        @(negedge clock);
        check("abort_busy_before_reset", mem_busy, 1'b1);
        reset     = 1'b1;
        write_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_ready", mem_ready, 1'b0);
            check("abort_busy", mem_busy, 1'b0);
            check("abort_dout", dout, HIZ);
            @(negedge clock);
        end
        run_txn("rd_40",   1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, 16'h5555, 1'b0, 1'b0);

`ifdef MEM_PARITY_EN
        run_txn("wr_par1", 1'b0, 1'b1, 8'h60, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_txn("rd_par1", 1'b1, 1'b0, 8'h60, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0);
        run_txn("wr_par0", 1'b0, 1'b1, 8'h60, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_txn("rd_par0", 1'b1, 1'b0, 8'h60, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
